// File: rtl/instruction_scheduler_mc_if.sv
// instruction_scheduler_mc_if: host command port, PE lane stream and status bundle.
// The scheduler takes the slave modport; whoever drives commands and PE ready takes master.
interface instruction_scheduler_mc_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 16,
   parameter int CMD_WIDTH  = 32,
   parameter int FIFO_DEPTH = 32
);
   localparam int PE_IDX_W = $clog2(NUM_PE);
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   logic [CMD_WIDTH-1:0]  cmd;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [DATA_WIDTH-1:0] pe_data;
   logic [PE_IDX_W-1:0]   pe_sel;
   logic                  pe_valid;
   logic                  pe_ready;
   logic                  busy;
   logic                  done;
   logic                  cmd_err;
   logic [CNT_W-1:0]      fifo_count;
   logic [31:0]           perf_stall_cycles;
   modport master (
      output cmd, cmd_valid, pe_ready,
      input  cmd_ready, pe_data, pe_sel, pe_valid, busy, done, cmd_err, fifo_count, perf_stall_cycles
   );
   modport slave (
      input  cmd, cmd_valid, pe_ready,
      output cmd_ready, pe_data, pe_sel, pe_valid, busy, done, cmd_err, fifo_count, perf_stall_cycles
   );
endinterface

// File: rtl/instruction_scheduler_mc.sv
// instruction_scheduler_mc: command FIFO feeding a lane-sweeping PE dispatcher.
// Define SCHED_PERF_CNT_EN to build the saturating backpressure stall counter.
module instruction_scheduler_mc #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 16,
   parameter int ITER_WIDTH = 8,
   parameter int CMD_WIDTH  = 32,
   parameter int FIFO_DEPTH = 32
) (
   input logic clk,
   input logic rst,
   instruction_scheduler_mc_if.slave bus
);
   localparam int PE_IDX_W = $clog2(NUM_PE);
   localparam int AW       = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, DISPATCH, DONE} state_t;
   state_t                state;
   logic [CMD_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic [AW:0]           count;
   logic [CMD_WIDTH-1:0]  head;
   logic [PE_IDX_W-1:0]   start, sel;
   logic [ITER_WIDTH-1:0] iter;
   logic [DATA_WIDTH-1:0] data;
   logic                  valid, done_pulse, err_pulse, push, pop, last_lane;
   logic                  unused_head;
   assign head        = mem[rptr];
   assign unused_head = ^head;
   assign start       = head[PE_IDX_W-1:0];
   assign push        = bus.cmd_valid && bus.cmd_ready;
   assign pop         = (state == IDLE) && (count != '0);
   assign last_lane   = sel == PE_IDX_W'(NUM_PE - 1);
   assign bus.cmd_ready  = count != (AW+1)'(FIFO_DEPTH);
   assign bus.fifo_count = count;
   assign bus.busy       = state != IDLE;
   assign bus.pe_valid   = valid;
   assign bus.pe_sel     = sel;
   assign bus.pe_data    = data;
   assign bus.done       = done_pulse;
   assign bus.cmd_err    = err_pulse;
   always_ff @(posedge clk)
      if (push) mem[wptr] <= bus.cmd;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         iter       <= '0;
         sel        <= '0;
         data       <= '0;
         valid      <= 1'b0;
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               iter <= head[PE_IDX_W+ITER_WIDTH-1:PE_IDX_W];
               if (32'(start) >= NUM_PE) err_pulse <= 1'b1;
               else begin
                  sel   <= start;
                  data  <= head[CMD_WIDTH-1 -: DATA_WIDTH];
                  valid <= 1'b1;
                  state <= DISPATCH;
               end
            end
            DISPATCH: if (bus.pe_ready) begin
               // Sweep to the top lane, then restart from lane 0 once per remaining iteration
               if (!last_lane) sel <= sel + 1'b1;
               else if (iter != '0) begin
                  iter <= iter - 1'b1;
                  sel  <= '0;
               end else begin
                  valid <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done_pulse <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] stall_cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) stall_cnt <= '0;
      else if (valid && !bus.pe_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   assign bus.perf_stall_cycles = stall_cnt;
`else
   assign bus.perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_instruction_scheduler_mc.sv
// tb_instruction_scheduler_mc: directed scenarios on a 16-lane and a 12-lane scheduler,
// with per-transfer lane/operand expectations queued as commands are accepted.
module tb_instruction_scheduler_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_scheduler_mc_if #(.NUM_PE(16)) a ();
   instruction_scheduler_mc_if #(.NUM_PE(12)) b ();
   instruction_scheduler_mc #(.NUM_PE(16)) u_a (.clk(clk), .rst(rst), .bus(a));
   instruction_scheduler_mc #(.NUM_PE(12)) u_b (.clk(clk), .rst(rst), .bus(b));

   int vectors = 0;
   int miscompares = 0;
   int done_a = 0, done_b = 0, err_b = 0;
   logic [19:0] q_a[$];
   logic [19:0] q_b[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input int start, input int iter, input logic [15:0] op);
      return {op, 4'h5, 8'(iter), 4'(start)};
   endfunction

   task automatic expect_cmd(input bit which, input int start, input int iter, input logic [15:0] op);
      int npe = which ? 12 : 16;
      for (int it = 0; it <= iter; it++)
         for (int s = (it == 0) ? start : 0; s < npe; s++)
            if (which) q_b.push_back({4'(s), op});
            else q_a.push_back({4'(s), op});
   endtask

   task automatic push_cmd(input bit which, input int start, input int iter, input logic [15:0] op);
      bit acc = 1'b0;
      if (which) begin b.cmd = mk(start, iter, op); b.cmd_valid = 1'b1; end
      else begin a.cmd = mk(start, iter, op); a.cmd_valid = 1'b1; end
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = which ? b.cmd_ready : a.cmd_ready;
         step();
      end
      a.cmd_valid = 1'b0;
      b.cmd_valid = 1'b0;
      chk("push_accept", 64'(acc), 64'(1));
      if (acc) expect_cmd(which, start, iter, op);
   endtask

   task automatic drain(input bit which);
      int i = 0;
      while (i < 3000 && (which ? (q_b.size() != 0 || b.busy || b.fifo_count != 0)
                                : (q_a.size() != 0 || a.busy || a.fifo_count != 0))) begin
         step();
         i++;
      end
      chk(which ? "drain_b_busy" : "drain_a_busy", 64'(which ? b.busy : a.busy), 64'(0));
      chk(which ? "drain_b_queue" : "drain_a_queue", 64'(which ? q_b.size() : q_a.size()), 64'(0));
      step();
   endtask

   always @(negedge clk) if (!rst) begin
      if (a.pe_valid && a.pe_ready) begin
         if (q_a.size() == 0) chk("a_xfer_unexpected", 64'(q_a.size()), 64'(1));
         else chk("a_xfer", 64'({a.pe_sel, a.pe_data}), 64'(q_a.pop_front()));
      end
      if (b.pe_valid && b.pe_ready) begin
         if (q_b.size() == 0) chk("b_xfer_unexpected", 64'(q_b.size()), 64'(1));
         else chk("b_xfer", 64'({b.pe_sel, b.pe_data}), 64'(q_b.pop_front()));
      end
      if (a.done) done_a++;
      if (b.done) done_b++;
      if (b.cmd_err) err_b++;
   end

   initial begin
      int n, d0, e0;
      a.cmd = '0; a.cmd_valid = 1'b0; a.pe_ready = 1'b0;
      b.cmd = '0; b.cmd_valid = 1'b0; b.pe_ready = 1'b0;
      rst = 1'b1;
      step(3);
      chk("rst_cmd_ready", 64'(a.cmd_ready), 64'(1));
      chk("rst_pe_valid", 64'(a.pe_valid), 64'(0));
      chk("rst_pe_data", 64'(a.pe_data), 64'(0));
      chk("rst_pe_sel", 64'(a.pe_sel), 64'(0));
      chk("rst_busy", 64'(a.busy), 64'(0));
      chk("rst_done", 64'(a.done), 64'(0));
      chk("rst_cmd_err", 64'(a.cmd_err), 64'(0));
      chk("rst_fifo_count", 64'(a.fifo_count), 64'(0));
      chk("rst_perf", 64'(a.perf_stall_cycles), 64'(0));
      chk("rst_b_pe_valid", 64'(b.pe_valid), 64'(0));
      rst = 1'b0;
      step(2);

      // start=14, iter=1: lanes 14,15 then a full 0..15 sweep
      a.pe_ready = 1'b1;
      d0 = done_a;
      push_cmd(0, 14, 1, 16'hABCD);
      chk("lat_count", 64'(a.fifo_count), 64'(1));
      chk("lat_valid_early", 64'(a.pe_valid), 64'(0));
      step();
      chk("lat_valid", 64'(a.pe_valid), 64'(1));
      chk("lat_sel", 64'(a.pe_sel), 64'(14));
      chk("lat_data", 64'(a.pe_data), 64'(16'hABCD));
      chk("lat_busy", 64'(a.busy), 64'(1));
      chk("lat_popped", 64'(a.fifo_count), 64'(0));
      n = 0;
      while (a.pe_valid && n < 100) begin n++; step(); end
      chk("t1_xfers", 64'(n), 64'(18));
      chk("t1_done_early", 64'(a.done), 64'(0));
      chk("t1_busy_in_done", 64'(a.busy), 64'(1));
      step();
      chk("t1_done", 64'(a.done), 64'(1));
      chk("t1_busy_off", 64'(a.busy), 64'(0));
      step();
      chk("t1_done_pulse", 64'(a.done), 64'(0));
      chk("t1_done_cnt", 64'(done_a - d0), 64'(1));

      // five stalled cycles at lane 3, then 13 transfers
      a.pe_ready = 1'b0;
      push_cmd(0, 3, 0, 16'h1234);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 64'(a.pe_valid), 64'(1));
         chk("stall_sel", 64'(a.pe_sel), 64'(3));
         chk("stall_data", 64'(a.pe_data), 64'(16'h1234));
         step();
      end
      a.pe_ready = 1'b1;
      n = 0;
      while (a.pe_valid && n < 100) begin n++; step(); end
      chk("t3_xfers", 64'(n), 64'(13));
`ifdef SCHED_PERF_CNT_EN
      chk("perf_stalls", 64'(a.perf_stall_cycles), 64'(5));
`else
      chk("perf_tied_zero", 64'(a.perf_stall_cycles), 64'(0));
`endif
      drain(0);

      // fill the FIFO behind a stalled dispatch
      a.pe_ready = 1'b0;
      d0 = done_a;
      for (int i = 0; i < 33; i++) push_cmd(0, i % 16, i % 2, 16'(i * 257 + 1));
      chk("full_count", 64'(a.fifo_count), 64'(32));
      chk("full_ready", 64'(a.cmd_ready), 64'(0));
      a.cmd = mk(1, 0, 16'hDEAD);
      a.cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("full_hold", 64'(a.fifo_count), 64'(32));
      end
      a.cmd_valid = 1'b0;
      a.pe_ready = 1'b1;
      drain(0);
      chk("fill_done_cnt", 64'(done_a - d0), 64'(33));

      // push lands in the same IDLE cycle that pops
      a.pe_ready = 1'b0;
      push_cmd(0, 15, 0, 16'h1111);
      push_cmd(0, 2, 0, 16'h2222);
      push_cmd(0, 9, 0, 16'h3333);
      chk("pp_pre_count", 64'(a.fifo_count), 64'(2));
      chk("pp_pre_sel", 64'(a.pe_sel), 64'(15));
      a.pe_ready = 1'b1;
      step();
      chk("pp_done_state", 64'(a.pe_valid), 64'(0));
      step();
      chk("pp_idle_count", 64'(a.fifo_count), 64'(2));
      chk("pp_idle_done", 64'(a.done), 64'(1));
      push_cmd(0, 6, 0, 16'h4444);
      chk("pp_count_same", 64'(a.fifo_count), 64'(2));
      chk("pp_dispatch", 64'(a.pe_valid), 64'(1));
      chk("pp_sel", 64'(a.pe_sel), 64'(2));
      drain(0);

      // asynchronous reset while parked on lane 7 with four queued
      a.pe_ready = 1'b0;
      push_cmd(0, 7, 0, 16'h7777);
      for (int i = 0; i < 4; i++) push_cmd(0, i, 0, 16'(16'h8000 + i));
      chk("rst_pre_sel", 64'(a.pe_sel), 64'(7));
      chk("rst_pre_count", 64'(a.fifo_count), 64'(4));
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(a.pe_valid), 64'(0));
      chk("arst_count", 64'(a.fifo_count), 64'(0));
      chk("arst_busy", 64'(a.busy), 64'(0));
      chk("arst_ready", 64'(a.cmd_ready), 64'(1));
      chk("arst_sel", 64'(a.pe_sel), 64'(0));
      chk("arst_perf", 64'(a.perf_stall_cycles), 64'(0));
      q_a.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      a.pe_ready = 1'b1;
      push_cmd(0, 5, 0, 16'h4242);
      step();
      chk("post_rst_valid", 64'(a.pe_valid), 64'(1));
      chk("post_rst_sel", 64'(a.pe_sel), 64'(5));
      drain(0);

      // illegal start on the 12-lane instance, then a legal one
      b.pe_ready = 1'b1;
      e0 = err_b;
      d0 = done_b;
      push_cmd(1, 13, 0, 16'hEEEE);
      chk("err_valid_c1", 64'(b.pe_valid), 64'(0));
      chk("err_count_c1", 64'(b.fifo_count), 64'(1));
      step();
      chk("err_pulse", 64'(b.cmd_err), 64'(1));
      chk("err_count", 64'(b.fifo_count), 64'(0));
      chk("err_valid", 64'(b.pe_valid), 64'(0));
      chk("err_busy", 64'(b.busy), 64'(0));
      step();
      chk("err_pulse_end", 64'(b.cmd_err), 64'(0));
      chk("err_valid_after", 64'(b.pe_valid), 64'(0));
      push_cmd(1, 10, 1, 16'h5A5A);
      step();
      chk("b_valid", 64'(b.pe_valid), 64'(1));
      chk("b_sel", 64'(b.pe_sel), 64'(10));
      drain(1);
      chk("b_err_cnt", 64'(err_b - e0), 64'(1));
      chk("b_done_cnt", 64'(done_b - d0), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
